// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - sequential eight-probe sprite/map collision scanner over a latency-ROM
module collision_scanner #(
    parameter int          NUM_PROBES  = 8,
    parameter int          ROM_LATENCY = 1,
    parameter int          SCALE_NUM   = 5,
    parameter int          SCALE_SHIFT = 4,
    parameter int          MAP_W       = 200,
    parameter int          PIX_W       = 640,
    parameter int          PIX_H       = 480,
    parameter int          PROBE_DX    = 8,
    parameter int          PROBE_DY    = 4,
    parameter logic [23:0] SOLID0      = 24'h716734,
    parameter logic [23:0] SOLID1      = 24'h5f582b
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [6:0]            width,
    input  logic [6:0]            height,
    output logic [16:0]           rom_addr,
    input  logic [23:0]           rom_data,
    output logic [NUM_PROBES-1:0] collide_flags,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [9:0]  DX       = 10'(PROBE_DX);
    localparam logic [9:0]  DY       = 10'(PROBE_DY);
    localparam logic [2:0]  LAST_IDX = 3'(NUM_PROBES - 1);
    localparam logic [15:0] LAT_LAST = 16'(ROM_LATENCY - 1);

    state_t                state, state_next;
    logic [9:0]            x_r, y_r, hw_r, hh_r;
    logic [2:0]            idx;
    logic [15:0]           wcnt;
    logic                  oor_r;
    logic [NUM_PROBES-1:0] shadow, shadow_upd;

    logic [9:0]  bx, by, bhw, bhh, px, py;
    logic [2:0]  bidx;
    logic [16:0] mx, my, addr_next;
    logic        oor_next, hit, wait_last, probe_last;

    assign wait_last  = (wcnt == LAT_LAST);
    assign probe_last = (idx == LAST_IDX);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign hit        = oor_r || (rom_data == SOLID0) || (rom_data == SOLID1);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_last) state_next = probe_last ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The address for the probe about to be issued: straight from the ports when
    // accepting a start, otherwise from the latched geometry for the next probe.
    always_comb begin
        if (state == IDLE) begin
            bx   = x;
            by   = y;
            bhw  = {4'd0, width[6:1]};
            bhh  = {4'd0, height[6:1]};
            bidx = 3'd0;
        end else begin
            bx   = x_r;
            by   = y_r;
            bhw  = hw_r;
            bhh  = hh_r;
            bidx = idx + 3'd1;
        end
        case (bidx)
            3'd0:    begin px = bx;       py = by - bhh;      end
            3'd1:    begin px = bx;       py = by + bhh;      end
            3'd2:    begin px = bx - bhw; py = by;            end
            3'd3:    begin px = bx + bhw; py = by;            end
            3'd4:    begin px = bx - DX;  py = by + bhh - DY; end
            3'd5:    begin px = bx + DX;  py = by + bhh - DY; end
            3'd6:    begin px = bx - DX;  py = by - bhh + DY; end
            default: begin px = bx + DX;  py = by - bhh + DY; end
        endcase
        mx        = ({7'd0, px} * 17'(SCALE_NUM)) >> SCALE_SHIFT;
        my        = ({7'd0, py} * 17'(SCALE_NUM)) >> SCALE_SHIFT;
        addr_next = mx + my * 17'(MAP_W);
        oor_next  = ({1'b0, px} >= 11'(PIX_W)) || ({1'b0, py} >= 11'(PIX_H));
    end

    always_comb begin
        shadow_upd = shadow;
        for (int i = 0; i < NUM_PROBES; i++) begin
            if (3'(i) == idx) shadow_upd[i] = hit;
        end
    end

    // Flags load on the edge into DONE so they are already valid while done is high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_r           <= '0;
            y_r           <= '0;
            hw_r          <= '0;
            hh_r          <= '0;
            idx           <= '0;
            wcnt          <= '0;
            oor_r         <= 1'b0;
            shadow        <= '0;
            collide_flags <= '0;
            rom_addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r      <= x;
                        y_r      <= y;
                        hw_r     <= {4'd0, width[6:1]};
                        hh_r     <= {4'd0, height[6:1]};
                        idx      <= 3'd0;
                        wcnt     <= '0;
                        shadow   <= '0;
                        rom_addr <= addr_next;
                        oor_r    <= oor_next;
                    end
                end
                ISSUE: wcnt <= '0;
                WAIT: begin
                    if (wait_last) begin
                        shadow <= shadow_upd;
                        if (probe_last) begin
                            collide_flags <= shadow_upd;
                        end else begin
                            idx      <= idx + 3'd1;
                            rom_addr <= addr_next;
                            oor_r    <= oor_next;
                        end
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                DONE:    idx <= 3'd0;
                default: idx <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - vector table, random model comparison and corner sequences for collision_scanner
module tb_collision_scanner;

    localparam logic [23:0] S0 = 24'h716734;
    localparam logic [23:0] S1 = 24'h5f582b;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [9:0]  x, y;
    logic [6:0]  width, height;
    logic [16:0] addr_d, addr_v;
    logic [23:0] data_d, data_v, data_v1;
    logic [7:0]  flags_d;
    logic [3:0]  flags_v;
    logic        busy_d, done_d, busy_v, done_v;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] rom_mem [int];

    always #5 clk = ~clk;

    collision_scanner u_dut (
        .Clk(clk), .Reset(rst), .start(start), .x(x), .y(y), .width(width), .height(height),
        .rom_addr(addr_d), .rom_data(data_d), .collide_flags(flags_d), .busy(busy_d), .done(done_d)
    );

    collision_scanner #(.NUM_PROBES(4), .ROM_LATENCY(2)) u_var (
        .Clk(clk), .Reset(rst), .start(start), .x(x), .y(y), .width(width), .height(height),
        .rom_addr(addr_v), .rom_data(data_v), .collide_flags(flags_v), .busy(busy_v), .done(done_v)
    );

    function automatic logic [23:0] rom_lookup(input logic [16:0] a);
        int k;
        k = int'(a);
        return rom_mem.exists(k) ? rom_mem[k] : 24'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            data_d  <= '0;
            data_v1 <= '0;
            data_v  <= '0;
        end else begin
            data_d  <= rom_lookup(addr_d);
            data_v1 <= rom_lookup(addr_v);
            data_v  <= data_v1;
        end
    end

    function automatic void probe_xy(input int p, input int sx, input int sy, input int sw,
                                     input int sh, output int px, output int py);
        int hw, hh;
        hw = sw / 2;
        hh = sh / 2;
        case (p)
            0:       begin px = sx;      py = sy - hh;     end
            1:       begin px = sx;      py = sy + hh;     end
            2:       begin px = sx - hw; py = sy;          end
            3:       begin px = sx + hw; py = sy;          end
            4:       begin px = sx - 8;  py = sy + hh - 4; end
            5:       begin px = sx + 8;  py = sy + hh - 4; end
            6:       begin px = sx - 8;  py = sy - hh + 4; end
            default: begin px = sx + 8;  py = sy - hh + 4; end
        endcase
        px = (px + 2048) % 1024;
        py = (py + 2048) % 1024;
    endfunction

    function automatic int probe_addr(input int px, input int py);
        return (((px * 5) / 16) + ((py * 5) / 16) * 200) % 131072;
    endfunction

    function automatic logic [7:0] model_flags(input int sx, input int sy, input int sw, input int sh);
        logic [7:0]  f;
        logic [23:0] c;
        int px, py, a;
        f = '0;
        for (int p = 0; p < 8; p++) begin
            probe_xy(p, sx, sy, sw, sh, px, py);
            a = probe_addr(px, py);
            c = rom_mem.exists(a) ? rom_mem[a] : 24'h0;
            f[p] = (px >= 640) || (py >= 480) || (c == S0) || (c == S1);
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One scan observed on both instances for a fixed 60-cycle window after the start edge.
    task automatic run_scan(input int sx, input int sy, input int sw, input int sh,
                            input int inj_a, input bit inj_done,
                            output int lat_d, output int lat_v, output int busy_cnt,
                            output int ndone, output int early, output int a0, output int a1,
                            output logic [7:0] fl_d, output logic [3:0] fl_v);
        logic [7:0] prev;
        lat_d = -1; lat_v = -1; busy_cnt = 0; ndone = 0; early = 0; a0 = -1; a1 = -1;
        fl_d = 'x; fl_v = 'x;
        @(negedge clk);
        prev   = flags_d;
        x      = 10'(sx);
        y      = 10'(sy);
        width  = 7'(sw);
        height = 7'(sh);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (busy_d) busy_cnt++;
            if (n == 1) a0 = int'(addr_d);
            if (n == 3) a1 = int'(addr_d);
            if (n == 2) begin
                x = 10'($urandom); y = 10'($urandom);
                width = 7'($urandom); height = 7'($urandom);
            end
            if (!done_d && flags_d !== prev) early++;
            if (done_d) begin
                ndone++;
                prev = flags_d;
                if (lat_d < 0) begin
                    lat_d = n;
                    fl_d  = flags_d;
                end
                if (inj_done) start = 1'b1;
            end
            if (done_v && lat_v < 0) begin
                lat_v = n;
                fl_v  = flags_v;
            end
            if (n == inj_a) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    typedef struct {
        int          x, y, w, h;
        int          sa;
        logic [23:0] col;
        logic [7:0]  ef;
        int          a0, a1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int lat_d, lat_v, busy_cnt, ndone, early, a0, a1;
        int px, py, r;
        logic [7:0] fl_d, ef;
        logic [3:0] fl_v;

        tbl[0] = '{320, 240, 20, 30, 0,     24'h0,      8'h00, 14100, 15900};
        tbl[1] = '{320, 240, 20, 30, 15900, 24'h716734, 8'h02, 14100, 15900};
        tbl[2] = '{320, 240, 20, 30, 14100, 24'h5f582b, 8'h01, 14100, 15900};
        tbl[3] = '{320, 240, 20, 30, 15900, 24'h716735, 8'h00, 14100, 15900};
        tbl[4] = '{5,   240, 20, 30, 0,     24'h0,      8'h54, 14001, 15801};
        tbl[5] = '{639, 240, 2,  30, 0,     24'h0,      8'hA8, 14199, 15999};
        tbl[6] = '{320, 0,   20, 20, 0,     24'h0,      8'hC1, 63300, 700};

        rst = 1'b1; start = 1'b0; x = '0; y = '0; width = '0; height = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy_d), 0);
        check("reset done", 32'(done_d), 0);
        check("reset flags", 32'(flags_d), 0);
        check("reset rom_addr", 32'(addr_d), 0);
        check("reset var busy", 32'(busy_v), 0);
        rst = 1'b0;

        foreach (tbl[e]) begin
            rom_mem.delete();
            if (tbl[e].col != 24'h0) rom_mem[tbl[e].sa] = tbl[e].col;
            run_scan(tbl[e].x, tbl[e].y, tbl[e].w, tbl[e].h, 0, 1'b0,
                     lat_d, lat_v, busy_cnt, ndone, early, a0, a1, fl_d, fl_v);
            check($sformatf("vec%0d flags", e), 32'(fl_d), 32'(tbl[e].ef));
            check($sformatf("vec%0d var flags", e), 32'(fl_v), 32'(tbl[e].ef[3:0]));
            check($sformatf("vec%0d done cycle", e), lat_d, 17);
            check($sformatf("vec%0d var done cycle", e), lat_v, 13);
            check($sformatf("vec%0d busy cycles", e), busy_cnt, 17);
            check($sformatf("vec%0d done count", e), ndone, 1);
            check($sformatf("vec%0d early flag change", e), early, 0);
            check($sformatf("vec%0d probe0 addr", e), a0, tbl[e].a0);
            check($sformatf("vec%0d probe1 addr", e), a1, tbl[e].a1);
        end

        for (int it = 0; it < 20; it++) begin
            int sx, sy, sw, sh;
            sx = (it % 2 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639);
            sy = (it % 2 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
            sw = $urandom_range(0, 127);
            sh = $urandom_range(0, 127);
            rom_mem.delete();
            for (int p = 0; p < 8; p++) begin
                probe_xy(p, sx, sy, sw, sh, px, py);
                r = $urandom_range(0, 3);
                if (r == 1) rom_mem[probe_addr(px, py)] = S0;
                if (r == 2) rom_mem[probe_addr(px, py)] = S1;
                if (r == 3) rom_mem[probe_addr(px, py)] = 24'($urandom) | 24'h800000;
            end
            ef = model_flags(sx, sy, sw, sh);
            run_scan(sx, sy, sw, sh, 0, 1'b0,
                     lat_d, lat_v, busy_cnt, ndone, early, a0, a1, fl_d, fl_v);
            check($sformatf("rand%0d flags", it), 32'(fl_d), 32'(ef));
            check($sformatf("rand%0d var flags", it), 32'(fl_v), 32'(ef[3:0]));
            check($sformatf("rand%0d done cycle", it), lat_d, 17);
            check($sformatf("rand%0d var done cycle", it), lat_v, 13);
        end

        rom_mem.delete();
        rom_mem[15900] = S0;
        run_scan(320, 240, 20, 30, 5, 1'b1,
                 lat_d, lat_v, busy_cnt, ndone, early, a0, a1, fl_d, fl_v);
        check("busy-start done count", ndone, 1);
        check("busy-start done cycle", lat_d, 17);
        check("busy-start busy cycles", busy_cnt, 17);
        check("busy-start flags", 32'(fl_d), 32'h02);

        @(negedge clk);
        check("pre-reset flags", 32'(flags_d), 32'h02);
        x = 10'd320; y = 10'd240; width = 7'd20; height = 7'd30; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid-scan busy", 32'(busy_d), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort flags", 32'(flags_d), 0);
        check("abort busy", 32'(busy_d), 0);
        check("abort done", 32'(done_d), 0);
        check("abort rom_addr", 32'(addr_d), 0);
        check("abort var flags", 32'(flags_v), 0);
        check("abort var busy", 32'(busy_v), 0);
        rst = 1'b0;
        run_scan(320, 240, 20, 30, 0, 1'b0,
                 lat_d, lat_v, busy_cnt, ndone, early, a0, a1, fl_d, fl_v);
        check("post-reset done cycle", lat_d, 17);
        check("post-reset done count", ndone, 1);
        check("post-reset flags", 32'(fl_d), 32'h02);
        check("post-reset var done cycle", lat_v, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
